// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that lends a shared even counter to one
// owner for a burst of len steps, then pulses done and rests one idle cycle.
module count_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [2:0]       len0,
    input  logic [2:0]       len1,
    output logic [1:0]       grant,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    // Handshake: req[i] is a level request that must stay high for the whole
    // burst; grant is the registered one-hot answer. Dropping req[owner]
    // while granted aborts the burst on the next edge without a done pulse.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [3:0]       rem_q, rem_d;
    logic             lp_q, lp_d;
    logic             done_q, done_d;

    logic             win;
    logic [2:0]       win_len;
    logic             owner;

    // On contention the requester that did not own the counter last wins.
    assign win     = (req == 2'b11) ? ~lp_q : req[1];
    assign win_len = win ? len1 : len0;
    assign owner   = grant_q[1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        rem_d   = rem_q;
        lp_d    = lp_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = RUN;
                    grant_d = win ? 2'b10 : 2'b01;
                    count_d = '0;
                    rem_d   = (win_len == 3'd0) ? 4'd8 : {1'b0, win_len};
                    lp_d    = win;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    count_d = '0;
                end else if (rem_q > 4'd1) begin
                    count_d = count_q + WIDTH'(2);
                    rem_d   = rem_q - 4'd1;
                end else begin
                    state_d = DONE;
                    grant_d = 2'b00;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                count_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // lp resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            count_q <= '0;
            rem_q   <= 4'd0;
            lp_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            lp_q    <= lp_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign count = count_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: per-scenario tasks push expected {grant,count,busy,done}
// words to a queue and pop them against the DUT at each falling edge.
module tb_count_arbiter;

    localparam int WIDTH = 3;
    localparam int EW    = 2 + WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [2:0]       len0;
    logic [2:0]       len1;
    logic [1:0]       grant;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .grant (grant),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    function automatic logic [EW-1:0] pk(input logic [1:0] g, input int c,
                                         input logic b, input logic d);
        logic [WIDTH-1:0] cv;
        cv = c[WIDTH-1:0];
        return {g, cv, b, d};
    endfunction

    // Count must stay even and grant must be one-hot or zero in every cycle.
    always @(negedge clk) begin
        checks++;
        assert (count[0] == 1'b0 && $onehot0(grant)) else begin
            errors++;
            $display("FAIL invariant t=%0t grant=%b count=%0d", $time, grant, count);
        end
    end

    task automatic test_reset();
        logic [EW-1:0] got, exp;
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        #3;
        got = {grant, count, busy, done};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", got, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_idle[%0d] got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [EW-1:0] got, exp;
        req  = 2'b01;
        len0 = 3'd3;
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 2, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 4, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 4, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i == 0) len0 = 3'd7;
            if (i == 3) req = 2'b00;
        end
    endtask

    task automatic test_wrap();
        logic [EW-1:0] got, exp;
        req  = 2'b10;
        len1 = 3'd0;
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(2'b10, (2 * i) % 8, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 6, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i == 0) begin
                len1 = 3'd3;
                req  = 2'b11;
            end
            if (i == 8) req = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        logic [EW-1:0] got, exp;
        req  = 2'b11;
        len0 = 3'd2;
        len1 = 3'd1;
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 2, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 2, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        exp_q.push_back(pk(2'b10, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 0, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 2, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 2, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL round_robin[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i == 10) req = 2'b00;
        end
    endtask

    task automatic test_abort();
        logic [EW-1:0] got, exp;
        req  = 2'b01;
        len0 = 3'd5;
        len1 = 3'd1;
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 2, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 4, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        exp_q.push_back(pk(2'b10, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 0, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i == 2) req = 2'b00;
            if (i == 3) req = 2'b11;
            if (i == 5) req = 2'b00;
        end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] got, exp;
        req  = 2'b01;
        len0 = 3'd4;
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b01, 2, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_run[%0d] got=%b exp=%b", i, got, exp);
            end
        end
        #2 reset = 1'b0;
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        #1;
        got = {grant, count, busy, done};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_mid_cycle got=%b exp=%b", got, exp);
        end
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        @(negedge clk);
        got = {grant, count, busy, done};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_held got=%b exp=%b", got, exp);
        end
        reset = 1'b1;
        req   = 2'b11;
        len0  = 3'd1;
        exp_q.push_back(pk(2'b01, 0, 1'b1, 1'b0));
        exp_q.push_back(pk(2'b00, 0, 1'b1, 1'b1));
        exp_q.push_back(pk(2'b00, 0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = {grant, count, busy, done};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_regrant[%0d] got=%b exp=%b", i, got, exp);
            end
            if (i == 1) req = 2'b00;
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        len0  = 3'd0;
        len1  = 3'd0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_abort();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d need=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
